// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side arbitration logic.
// Holds the FSM state encoding and the default sizing parameters.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    CLEANUP   = 3'd4
  } arb_state_t;

  localparam int DEF_N            = 4;
  localparam int DEF_BUSY_TIMEOUT = 4;

endpackage

// File: rtl/tx_arbiter_if.sv
// Bundle of requester-side and Tx-side signals around the transmit arbiter.
// master = arbiter, slave = clients plus the Tx instance.
interface tx_arbiter_if import uart_pkg::*; #(
  parameter int N = DEF_N
) ();

  // Handshake: requester i holds req[i] (and req_data byte i while it may
  // still win) until it sees done[i]; done is a one-cycle pulse and err rides
  // on it when Tx never raised busy. req high after done is a fresh request.
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic           tx_busy;
  logic           tx_write_en;
  logic [7:0]     tx_data;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           err;
  logic           active;

  modport master (
    input  req, req_data, tx_busy,
    output tx_write_en, tx_data, grant, done, err, active
  );

  modport slave (
    output req, req_data, tx_busy,
    input  tx_write_en, tx_data, grant, done, err, active
  );

endinterface

// File: rtl/tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr,
// wrapping modulo N. Returns the winner one-hot and as an index.
module rr_pick import uart_pkg::*; #(
  parameter int N  = DEF_N,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic [PW-1:0] idx
);

  logic        found;
  logic [PW:0] pos;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    pos    = '0;
    for (int i = 0; i < N; i++) begin
      // One spare bit so ptr + i cannot overflow before the explicit wrap.
      pos = {1'b0, ptr} + (PW+1)'(i);
      if (pos >= (PW+1)'(N)) pos = pos - (PW+1)'(N);
      if (!found && req[pos[PW-1:0]]) begin
        found                = 1'b1;
        winner[pos[PW-1:0]]  = 1'b1;
        idx                  = pos[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin sharing of one UART Tx between N byte requesters: grants,
// issues a single write_en, follows Tx busy and returns a per-owner done.
module tx_arbiter import uart_pkg::*; #(
  parameter int N            = DEF_N,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  tx_arbiter_if.master  bus,
  output arb_state_t    dbg_state
);

  localparam int PW      = $clog2(N);
  localparam int CW      = $clog2(BUSY_TIMEOUT + 1);
  // The counter is cleared in ISSUE, so matching BUSY_TIMEOUT-2 here puts
  // done/err exactly BUSY_TIMEOUT cycles after write_en (BUSY_TIMEOUT >= 2).
  localparam int TO_LAST = (BUSY_TIMEOUT > 2) ? BUSY_TIMEOUT - 2 : 0;
  localparam logic [PW-1:0] LAST_IDX = PW'(N - 1);

  arb_state_t    state, state_nxt;
  logic [PW-1:0] ptr, ptr_nxt;
  logic [PW-1:0] owner, owner_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [N-1:0]  grant_q, grant_nxt;
  logic [7:0]    data_q, data_nxt;
  logic          we_q, we_nxt;
  logic [N-1:0]  done_q, done_nxt;
  logic          err_q, err_nxt;
  logic          active_q, active_nxt;

  logic [N-1:0]  pick_onehot;
  logic [PW-1:0] pick_idx;

  rr_pick #(.N(N), .PW(PW)) u_pick (
    .req    (bus.req),
    .ptr    (ptr),
    .winner (pick_onehot),
    .idx    (pick_idx)
  );

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    owner_nxt  = owner;
    cnt_nxt    = cnt;
    grant_nxt  = grant_q;
    data_nxt   = data_q;
    we_nxt     = 1'b0;
    done_nxt   = '0;
    err_nxt    = 1'b0;
    active_nxt = active_q;

    unique case (state)
      IDLE: begin
        // A foreign transfer on Tx blocks arbitration entirely.
        if ((|bus.req) && !bus.tx_busy) begin
          grant_nxt  = pick_onehot;
          data_nxt   = bus.req_data[{pick_idx, 3'b000} +: 8];
          we_nxt     = 1'b1;
          active_nxt = 1'b1;
          owner_nxt  = pick_idx;
          state_nxt  = ISSUE;
        end
      end
      ISSUE: begin
        cnt_nxt   = '0;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (cnt == CW'(TO_LAST)) begin
          done_nxt  = grant_q;
          err_nxt   = 1'b1;
          state_nxt = CLEANUP;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          done_nxt  = grant_q;
          state_nxt = CLEANUP;
        end
      end
      CLEANUP: begin
        grant_nxt  = '0;
        active_nxt = 1'b0;
        ptr_nxt    = (owner == LAST_IDX) ? '0 : owner + PW'(1);
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      cnt      <= '0;
      grant_q  <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      done_q   <= '0;
      err_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      owner    <= owner_nxt;
      cnt      <= cnt_nxt;
      grant_q  <= grant_nxt;
      data_q   <= data_nxt;
      we_q     <= we_nxt;
      done_q   <= done_nxt;
      err_q    <= err_nxt;
      active_q <= active_nxt;
    end
  end

  assign bus.tx_write_en = we_q;
  assign bus.tx_data     = data_q;
  assign bus.grant       = grant_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.active      = active_q;
  assign dbg_state       = state;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: a table of frames with hand-computed grants,
// bytes and latencies, plus foreign-busy and mid-frame reset sequences.
module tb_tx_arbiter;
  import uart_pkg::*;

  localparam int N        = 4;
  localparam int BT       = 4;
  localparam int FRAME    = 12;
  localparam int NORM_LAT = FRAME + 2;
  localparam logic [8*N-1:0] D4  = 32'h44332211;
  localparam logic [8*N-1:0] DA5 = 32'h443322A5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tx_arbiter_if #(.N(N)) bus ();
  arb_state_t dbg_state;

  tx_arbiter #(.N(N), .BUSY_TIMEOUT(BT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- Tx model ----------------
  // busy rises the cycle after write_en and stays high FRAME cycles.
  logic stuck;
  logic force_busy;
  int   busy_cnt = 0;

  always @(posedge clk) begin
    if (bus.tx_write_en && !stuck) busy_cnt <= FRAME;
    else if (busy_cnt != 0)        busy_cnt <= busy_cnt - 1;
  end

  assign bus.tx_busy = force_busy | (busy_cnt != 0);

  // ---------------- scoreboard ----------------
  int checks = 0;
  int passes = 0;
  int we_seen = 0;
  int exp_we = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (bus.tx_write_en) begin
      we_seen++;
      if (exp_q.size() != 0) check("tx_data", 32'(bus.tx_data), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [N-1:0]   req;
    logic [8*N-1:0] data;
    logic           stuck;
    logic [N-1:0]   exp_grant;
    logic [7:0]     exp_byte;
    logic           exp_err;
    int             exp_lat;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  // ---------------- driver ----------------
  task automatic run_frame(input vec_t v, input string tag);
    int t;
    exp_q.push_back(v.exp_byte);
    exp_we++;
    bus.req      = v.req;
    bus.req_data = v.data;
    stuck        = v.stuck;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.tx_write_en && t < 64);
    check({tag, "_arb_latency"}, t, 1);
    check({tag, "_grant"}, 32'(bus.grant), 32'(v.exp_grant));
    check({tag, "_active"}, 32'(bus.active), 1);
    @(negedge clk);
    t = 1;
    check({tag, "_we_width"}, 32'(bus.tx_write_en), 0);
    while (bus.done == '0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_done"}, 32'(bus.done), 32'(v.exp_grant));
    check({tag, "_err"}, 32'(bus.err), 32'(v.exp_err));
    check({tag, "_done_latency"}, t, v.exp_lat);
    check({tag, "_we_count"}, we_seen, exp_we);
    bus.req = '0;
    stuck   = 1'b0;
    @(negedge clk);
    check({tag, "_idle"}, 32'({bus.grant, bus.active, bus.done, bus.err}), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int blocked;
    int done_seen;
    int w;

    // Pointer after each row is noted; rows depend on the previous one.
    vecs[0]  = '{4'b1111, D4,  1'b0, 4'b0001, 8'h11, 1'b0, NORM_LAT}; // ptr->1
    vecs[1]  = '{4'b1111, D4,  1'b0, 4'b0010, 8'h22, 1'b0, NORM_LAT}; // ptr->2
    vecs[2]  = '{4'b1111, D4,  1'b0, 4'b0100, 8'h33, 1'b0, NORM_LAT}; // ptr->3
    vecs[3]  = '{4'b1111, D4,  1'b0, 4'b1000, 8'h44, 1'b0, NORM_LAT}; // ptr->0
    vecs[4]  = '{4'b1111, D4,  1'b0, 4'b0001, 8'h11, 1'b0, NORM_LAT}; // ptr->1
    vecs[5]  = '{4'b0001, DA5, 1'b0, 4'b0001, 8'hA5, 1'b0, NORM_LAT}; // ptr->1
    vecs[6]  = '{4'b1000, D4,  1'b0, 4'b1000, 8'h44, 1'b0, NORM_LAT}; // ptr->0
    vecs[7]  = '{4'b1001, D4,  1'b0, 4'b0001, 8'h11, 1'b0, NORM_LAT}; // ptr->1
    vecs[8]  = '{4'b1001, D4,  1'b0, 4'b1000, 8'h44, 1'b0, NORM_LAT}; // ptr->0
    vecs[9]  = '{4'b0110, D4,  1'b0, 4'b0010, 8'h22, 1'b0, NORM_LAT}; // ptr->2
    vecs[10] = '{4'b0110, D4,  1'b0, 4'b0100, 8'h33, 1'b0, NORM_LAT}; // ptr->3
    vecs[11] = '{4'b0011, D4,  1'b0, 4'b0001, 8'h11, 1'b0, NORM_LAT}; // ptr->1
    vecs[12] = '{4'b0100, D4,  1'b1, 4'b0100, 8'h33, 1'b1, BT};       // ptr->3
    vecs[13] = '{4'b0101, D4,  1'b0, 4'b0001, 8'h11, 1'b0, NORM_LAT}; // ptr->1

    rst          = 1'b0;
    bus.req      = '0;
    bus.req_data = '0;
    stuck        = 1'b0;
    force_busy   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({bus.tx_write_en, bus.tx_data, bus.grant, bus.done, bus.err, bus.active}), 0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) run_frame(vecs[i], $sformatf("row%0d", i));

    // Foreign busy: no grant while Tx is busy in IDLE.
    force_busy   = 1'b1;
    bus.req      = 4'b0010;
    bus.req_data = D4;
    exp_q.push_back(8'h22);
    exp_we++;
    blocked = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.tx_write_en || bus.grant != '0) blocked++;
    end
    check("fb_blocked", blocked, 0);
    force_busy = 1'b0;
    @(negedge clk);
    check("fb_write_en", 32'(bus.tx_write_en), 1);
    check("fb_grant", 32'(bus.grant), 32'(4'b0010));

    // Reset asserted while the frame sits in WAIT_DONE.
    repeat (4) @(negedge clk);
    check("rst_pre_state", 32'(dbg_state), 32'(WAIT_DONE));
    rst = 1'b0;
    @(negedge clk);
    check("rst_outputs", 32'({bus.tx_write_en, bus.tx_data, bus.grant, bus.done, bus.err, bus.active}), 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    bus.req = '0;
    done_seen = 0;
    w = 0;
    while (bus.tx_busy && w < 40) begin
      @(negedge clk);
      if (bus.done != '0) done_seen++;
      w++;
    end
    check("rst_busy_cleared", 32'(bus.tx_busy), 0);
    check("rst_no_done", done_seen, 0);
    rst = 1'b1;
    @(negedge clk);

    // Pointer back at 0: requester 0 wins among all four.
    run_frame('{4'b1111, D4, 1'b0, 4'b0001, 8'h11, 1'b0, NORM_LAT}, "post_rst");

    check("exp_q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
